// File: rtl/regfile_wb_arbiter_if.sv
// Bus bundle between writeback requesters, issue logic and the regfile write-port arbiter.
interface regfile_wb_arbiter_if #(
  parameter int unsigned XLEN           = 32,
  parameter int unsigned NUM_REQ        = 2,
  parameter int unsigned REG_IDX_W      = 5,
  parameter int unsigned REGISTER_COUNT = 32
);

  // Writeback request side
  logic [NUM_REQ-1:0]           req_valid;
  logic [NUM_REQ*REG_IDX_W-1:0] req_rd;
  logic [NUM_REQ*XLEN-1:0]      req_data;
  logic [NUM_REQ-1:0]           req_ready;

  // Regfile write port
  logic                         rd_wen;
  logic [REG_IDX_W-1:0]         rd_addr;
  logic [XLEN-1:0]              rd_wdata;

  // Issue-side scoreboard access
  logic                         rsv_valid;
  logic [REG_IDX_W-1:0]         rsv_rd;
  logic [REG_IDX_W-1:0]         chk_rs1;
  logic [REG_IDX_W-1:0]         chk_rs2;
  logic                         rs1_busy;
  logic                         rs2_busy;
  logic [REGISTER_COUNT-1:0]    pending;

  // Arbiter side
  modport slave (
    input  req_valid, req_rd, req_data, rsv_valid, rsv_rd, chk_rs1, chk_rs2,
    output req_ready, rd_wen, rd_addr, rd_wdata, rs1_busy, rs2_busy, pending
  );

  // Requester / issue / regfile side
  modport master (
    output req_valid, req_rd, req_data, rsv_valid, rsv_rd, chk_rs1, chk_rs2,
    input  req_ready, rd_wen, rd_addr, rd_wdata, rs1_busy, rs2_busy, pending
  );

endinterface

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter for the single regfile write port plus a pending-write scoreboard
// used by issue to detect RAW hazards on rs1/rs2.
module regfile_wb_arbiter #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned NUM_REQ = 2
) (
  input logic                clk,
  input logic                n_rst,
  regfile_wb_arbiter_if.slave bus
);

  localparam int unsigned REGISTER_COUNT = 32;
  localparam int unsigned REG_IDX_W      = 5;
  localparam int unsigned PTR_W          = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PTR_W-1:0]          rr_ptr_q, rr_ptr_d;
  logic [REGISTER_COUNT-1:0] pending_q, pending_d;

  logic                      grant_found;
  logic [PTR_W-1:0]          grant_idx;
  logic [PTR_W-1:0]          cand;
  logic [REG_IDX_W-1:0]      grant_rd;
  logic [XLEN-1:0]           grant_data;
  logic                      handshake;

  logic [REG_IDX_W-1:0]      rd_slot   [NUM_REQ];
  logic [XLEN-1:0]           data_slot [NUM_REQ];

  // Unpack the flat request buses into per-requester slots
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      rd_slot[i]   = bus.req_rd[i*REG_IDX_W +: REG_IDX_W];
      data_slot[i] = bus.req_data[i*XLEN +: XLEN];
    end
  end

  // First valid requester at or after rr_ptr, wrapping; nothing is granted while in reset
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int unsigned off = 0; off < NUM_REQ; off++) begin
      cand = PTR_W'((32'(rr_ptr_q) + off) % NUM_REQ);
      if (!grant_found && bus.req_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
    if (!n_rst) begin
      grant_found = 1'b0;
    end
  end

  assign handshake  = grant_found;
  assign grant_rd   = grant_found ? rd_slot[grant_idx] : '0;
  assign grant_data = grant_found ? data_slot[grant_idx] : '0;

  // Grant and write-port outputs; x0 writes are consumed without a regfile write
  always_comb begin
    bus.req_ready = '0;
    if (grant_found) begin
      bus.req_ready[grant_idx] = 1'b1;
    end
    bus.rd_addr  = grant_rd;
    bus.rd_wdata = grant_data;
    bus.rd_wen   = handshake && (grant_rd != '0);
  end

  // Next pointer and scoreboard: clear on writeback first so a same-cycle reserve wins
  always_comb begin
    rr_ptr_d  = rr_ptr_q;
    pending_d = pending_q;
    if (handshake) begin
      rr_ptr_d            = PTR_W'((32'(grant_idx) + 1) % NUM_REQ);
      pending_d[grant_rd] = 1'b0;
    end
    if (bus.rsv_valid && (bus.rsv_rd != '0)) begin
      pending_d[bus.rsv_rd] = 1'b1;
    end
    pending_d[0] = 1'b0;
  end

  // State registers
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      rr_ptr_q  <= '0;
      pending_q <= '0;
    end else begin
      rr_ptr_q  <= rr_ptr_d;
      pending_q <= pending_d;
    end
  end

  // Busy reflects registered pending, so it drops only once the regfile holds the new value
  always_comb begin
    bus.rs1_busy = n_rst && pending_q[bus.chk_rs1];
    bus.rs2_busy = n_rst && pending_q[bus.chk_rs2];
    bus.pending  = pending_q;
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: a scoreboard queue holds expected write-port
// handshakes and a negedge monitor pops/compares them; scoreboard state is checked inline.
module tb_regfile_wb_arbiter;

  localparam int XLEN = 32;
  localparam int NREQ = 2;

  typedef struct {
    logic [1:0]  ready;
    logic        wen;
    logic [4:0]  addr;
    logic [31:0] data;
  } exp_t;

  logic clk;
  logic n_rst;

  regfile_wb_arbiter_if #(.XLEN(XLEN), .NUM_REQ(NREQ)) bus ();

  regfile_wb_arbiter #(.XLEN(XLEN), .NUM_REQ(NREQ)) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  int   n_checks = 0;
  int   n_fails  = 0;
  exp_t exp_q[$];
  logic [31:0] tb_rf [32];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, req, $time);
    end
  endtask

  task automatic push_exp(input logic [1:0] r, input logic w, input logic [4:0] a,
                          input logic [31:0] d);
    exp_t e;
    e.ready = r;
    e.wen   = w;
    e.addr  = a;
    e.data  = d;
    exp_q.push_back(e);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic [4:0] rd, input logic [31:0] d);
    bus.req_valid[i]          = v;
    bus.req_rd[i*5 +: 5]      = rd;
    bus.req_data[i*32 +: 32]  = d;
  endtask

  // Regfile model: write lands at the handshake edge
  always @(posedge clk) begin
    if (bus.rd_wen) tb_rf[bus.rd_addr] <= bus.rd_wdata;
  end

  // Monitor: every handshake must match the next expected write-port transaction
  always @(negedge clk) begin
    exp_t e;
    if (n_rst && ((bus.req_valid & bus.req_ready) != '0)) begin
      if (exp_q.size() == 0) begin
        check("unexpected_handshake", 32'(bus.req_ready), 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("mon_grant", 32'(bus.req_ready), 32'(e.ready));
        check("mon_wen",   32'(bus.rd_wen),    32'(e.wen));
        check("mon_addr",  32'(bus.rd_addr),   32'(e.addr));
        check("mon_data",  bus.rd_wdata,       e.data);
      end
    end
  end

  initial begin
    n_rst         = 1'b0;
    bus.req_valid = '0;
    bus.req_rd    = '0;
    bus.req_data  = '0;
    bus.rsv_valid = 1'b0;
    bus.rsv_rd    = '0;
    bus.chk_rs1   = '0;
    bus.chk_rs2   = '0;

    // 1: reset state
    #2;
    check("rst_ready", 32'(bus.req_ready), 32'd0);
    check("rst_wen", 32'(bus.rd_wen), 32'd0);
    check("rst_pending", bus.pending, 32'd0);
    cyc();
    cyc();
    n_rst = 1'b1;
    cyc();
    check("idle_ready", 32'(bus.req_ready), 32'd0);
    check("idle_wen", 32'(bus.rd_wen), 32'd0);
    check("idle_pending", bus.pending, 32'd0);
    for (int i = 0; i < 32; i++) begin
      bus.chk_rs1 = 5'(i);
      bus.chk_rs2 = 5'(31 - i);
      #1;
      check("idle_rs1_busy", 32'(bus.rs1_busy), 32'd0);
      check("idle_rs2_busy", 32'(bus.rs2_busy), 32'd0);
    end

    // 2: reserve x5, write it back from req0
    bus.rsv_valid = 1'b1;
    bus.rsv_rd    = 5'd5;
    cyc();
    bus.rsv_valid = 1'b0;
    bus.chk_rs1   = 5'd5;
    bus.chk_rs2   = 5'd0;
    #1;
    check("rsv5_busy", 32'(bus.rs1_busy), 32'd1);
    check("rsv5_pending", bus.pending, 32'h0000_0020);
    push_exp(2'b01, 1'b1, 5'd5, 32'hAAAA_0001);
    set_req(0, 1'b1, 5'd5, 32'hAAAA_0001);
    #1;
    check("wb5_ready", 32'(bus.req_ready), 32'h1);
    check("wb5_busy_hs", 32'(bus.rs1_busy), 32'd1);
    cyc();
    set_req(0, 1'b0, 5'd0, 32'd0);
    #1;
    check("wb5_busy_after", 32'(bus.rs1_busy), 32'd0);
    check("wb5_pending", bus.pending, 32'd0);
    check("wb5_regfile", tb_rf[5], 32'hAAAA_0001);

    // 4: req1 writes x0 (rr_ptr is 1 now); reserving x0 is ignored too
    push_exp(2'b10, 1'b0, 5'd0, 32'hFFFF_FFFF);
    set_req(1, 1'b1, 5'd0, 32'hFFFF_FFFF);
    bus.rsv_valid = 1'b1;
    bus.rsv_rd    = 5'd0;
    bus.chk_rs1   = 5'd0;
    #1;
    check("x0_ready", 32'(bus.req_ready), 32'h2);
    check("x0_wen", 32'(bus.rd_wen), 32'd0);
    check("x0_busy", 32'(bus.rs1_busy), 32'd0);
    cyc();
    set_req(1, 1'b0, 5'd0, 32'd0);
    bus.rsv_valid = 1'b0;
    #1;
    check("x0_pending", bus.pending, 32'd0);
    check("x0_busy_after", 32'(bus.rs1_busy), 32'd0);

    // 3: both requesters continuously valid, grants alternate starting at 0
    set_req(0, 1'b1, 5'd1, 32'h0000_0111);
    set_req(1, 1'b1, 5'd2, 32'h0000_0222);
    for (int k = 0; k < 8; k++) begin
      if (k % 2 == 0) push_exp(2'b01, 1'b1, 5'd1, 32'h0000_0111);
      else            push_exp(2'b10, 1'b1, 5'd2, 32'h0000_0222);
    end
    for (int k = 0; k < 8; k++) begin
      #1;
      check("rr_grant", 32'(bus.req_ready), (k % 2 == 0) ? 32'h1 : 32'h2);
      cyc();
    end
    set_req(0, 1'b0, 5'd0, 32'd0);
    set_req(1, 1'b0, 5'd0, 32'd0);

    // 5: clear and reserve x7 in the same cycle keeps it pending
    bus.rsv_valid = 1'b1;
    bus.rsv_rd    = 5'd7;
    cyc();
    #1;
    check("rsv7_pending", bus.pending, 32'h0000_0080);
    push_exp(2'b01, 1'b1, 5'd7, 32'h0000_0077);
    set_req(0, 1'b1, 5'd7, 32'h0000_0077);
    cyc();
    set_req(0, 1'b0, 5'd0, 32'd0);
    bus.rsv_valid = 1'b0;
    bus.chk_rs2   = 5'd7;
    #1;
    check("clr_rsv7_pending", bus.pending, 32'h0000_0080);
    check("clr_rsv7_busy", 32'(bus.rs2_busy), 32'd1);
    push_exp(2'b01, 1'b1, 5'd7, 32'h0000_0078);
    set_req(0, 1'b1, 5'd7, 32'h0000_0078);
    cyc();
    set_req(0, 1'b0, 5'd0, 32'd0);
    #1;
    check("clr7_pending", bus.pending, 32'd0);

    // 6: reset mid-handshake with x5/x7 pending (rr_ptr is 1, so req1 holds the grant)
    bus.rsv_valid = 1'b1;
    bus.rsv_rd    = 5'd5;
    cyc();
    bus.rsv_rd    = 5'd7;
    cyc();
    bus.rsv_valid = 1'b0;
    #1;
    check("pre_rst_pending", bus.pending, 32'h0000_00A0);
    set_req(0, 1'b1, 5'd9, 32'h0000_0909);
    set_req(1, 1'b1, 5'd10, 32'h0000_0A0A);
    #1;
    check("pre_rst_ready", 32'(bus.req_ready), 32'h2);
    n_rst = 1'b0;
    #1;
    check("mid_rst_pending", bus.pending, 32'd0);
    check("mid_rst_ready", 32'(bus.req_ready), 32'd0);
    check("mid_rst_wen", 32'(bus.rd_wen), 32'd0);
    check("mid_rst_busy", 32'(bus.rs2_busy), 32'd0);
    cyc();
    push_exp(2'b01, 1'b1, 5'd9, 32'h0000_0909);
    push_exp(2'b10, 1'b1, 5'd10, 32'h0000_0A0A);
    n_rst = 1'b1;
    #1;
    check("post_rst_ready", 32'(bus.req_ready), 32'h1);
    cyc();
    set_req(0, 1'b0, 5'd0, 32'd0);
    #1;
    check("post_rst_ready2", 32'(bus.req_ready), 32'h2);
    cyc();
    set_req(1, 1'b0, 5'd0, 32'd0);
    cyc();
    cyc();
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
